// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol monitor: tracks IDLE/SETUP/ACCESS on the master side of a
// bridge and reports rule violations via sticky flags, first-error capture and counters.
module apb_protocol_monitor #(
    parameter int PADDR_SIZE     = 32,
    parameter int PDATA_SIZE     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_SIZE       = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [NUM_SLAVES-1:0]   PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [2:0]              PPROT,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic                    clr,
    output logic [6:0]              err_flags,
    output logic                    err_valid,
    output logic [2:0]              first_code,
    output logic [PADDR_SIZE-1:0]   first_addr,
    output logic [CNT_SIZE-1:0]     xfer_count,
    output logic [CNT_SIZE-1:0]     err_count,
    output logic [CNT_SIZE-1:0]     slverr_count,
    output logic [1:0]              mon_state
);

    localparam int STRB_SIZE = PDATA_SIZE / 8;
    localparam int BUS_W     = NUM_SLAVES + PADDR_SIZE + 1 + PDATA_SIZE + STRB_SIZE + 3;
    localparam int WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    function automatic logic multi_hot(input logic [NUM_SLAVES-1:0] v);
        return (v & (v - NUM_SLAVES'(1))) != '0;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [6:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            idx = v[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [BUS_W-1:0]        cap_q, cap_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    done_q, done_d;
    logic [6:0]              flags_q;
    logic                    valid_q;
    logic [2:0]              code_q;
    logic [PADDR_SIZE-1:0]   addr_q;
    logic [CNT_SIZE-1:0]     xfer_q, err_q, slv_q;

    logic                    sel_s;
    logic [BUS_W-1:0]        bus_s;
    logic [6:0]              viol_s;

    assign sel_s = |PSEL;
    assign bus_s = {PSEL, PADDR, PWRITE, PWDATA, PSTRB, PPROT};

    // Next-state, bus capture and per-cycle violation decode
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        viol_s  = 7'd0;
        viol_s[0] = multi_hot(PSEL);
        viol_s[5] = done_q & PENABLE & (state_q != ST_ACCESS);
        viol_s[6] = sel_s & ~PWRITE & (PSTRB != '0);
        case (state_q)
            ST_IDLE: begin
                if (sel_s) begin
                    cap_d  = bus_s;
                    wait_d = '0;
                    if (PENABLE) begin
                        viol_s[1] = 1'b1;
                        state_d   = ST_ACCESS;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!sel_s) begin
                    viol_s[2] = 1'b1;
                    state_d   = ST_IDLE;
                end else if (PENABLE) begin
                    state_d = ST_ACCESS;
                    wait_d  = '0;
                end else begin
                    viol_s[2] = 1'b1;
                    cap_d     = bus_s;
                end
            end
            ST_ACCESS: begin
                if (!sel_s) begin
                    viol_s[3] = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    viol_s[3] = (bus_s != cap_q);
                    if (PREADY) begin
                        done_d = 1'b1;
                        if (!PENABLE) begin
                            state_d = ST_SETUP;
                            cap_d   = bus_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (wait_q != WAIT_W'(TIMEOUT_CYCLES)) begin
                        // Counter parks at the limit so the timeout flag fires once per transfer
                        wait_d    = wait_q + WAIT_W'(1);
                        viol_s[4] = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
                    end else begin
                        wait_d = wait_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state plus reporting registers; clr wipes reporting only
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            flags_q <= 7'd0;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            addr_q  <= '0;
            xfer_q  <= '0;
            err_q   <= '0;
            slv_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            if (clr) begin
                flags_q <= 7'd0;
                valid_q <= 1'b0;
                code_q  <= 3'd0;
                addr_q  <= '0;
                xfer_q  <= '0;
                err_q   <= '0;
                slv_q   <= '0;
            end else begin
                flags_q <= flags_q | viol_s;
                valid_q <= |viol_s;
                if ((flags_q == 7'd0) && (|viol_s)) begin
                    code_q <= lowest_set(viol_s);
                    addr_q <= PADDR;
                end
                if ((|viol_s) && (err_q != '1)) begin
                    err_q <= err_q + CNT_SIZE'(1);
                end
                if (done_d && (xfer_q != '1)) begin
                    xfer_q <= xfer_q + CNT_SIZE'(1);
                end
                if (done_d && PSLVERR && (slv_q != '1)) begin
                    slv_q <= slv_q + CNT_SIZE'(1);
                end
            end
        end
    end

    assign err_flags    = flags_q;
    assign err_valid    = valid_q;
    assign first_code   = code_q;
    assign first_addr   = addr_q;
    assign xfer_count   = xfer_q;
    assign err_count    = err_q;
    assign slverr_count = slv_q;
    assign mon_state    = state_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Self-checking bench for apb_protocol_monitor: directed scenarios with literal
// expectations plus randomized bus traffic checked every cycle against a behavioural model.
module tb_apb_protocol_monitor;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NS   = 4;
    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int SW   = DW / 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          PCLK = 1'b0;
    logic          PRESET, PENABLE, PWRITE, PREADY, PSLVERR, clr;
    logic [NS-1:0] PSEL;
    logic [2:0]    PPROT;
    logic [SW-1:0] PSTRB;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [6:0]    err_flags;
    logic          err_valid;
    logic [2:0]    first_code;
    logic [AW-1:0] first_addr;
    logic [CW-1:0] xfer_count, err_count, slverr_count;
    logic [1:0]    mon_state;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // behavioural model state
    int            m_phase;
    int            m_waits;
    bit            m_prev_done;
    logic [NS-1:0] s_sel;
    logic [AW-1:0] s_addr;
    logic          s_write;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_strb;
    logic [2:0]    s_prot;
    logic [6:0]    e_flags;
    logic          e_valid;
    logic [2:0]    e_code;
    logic [AW-1:0] e_addr;
    int            e_xfer, e_err, e_slv;

    apb_protocol_monitor #(
        .PADDR_SIZE(AW), .PDATA_SIZE(DW), .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(TO), .CNT_SIZE(CW)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PPROT(PPROT), .PSTRB(PSTRB), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .clr(clr),
        .err_flags(err_flags), .err_valid(err_valid), .first_code(first_code),
        .first_addr(first_addr), .xfer_count(xfer_count), .err_count(err_count),
        .slverr_count(slverr_count), .mon_state(mon_state)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic snap();
        s_sel = PSEL; s_addr = PADDR; s_write = PWRITE;
        s_wdata = PWDATA; s_strb = PSTRB; s_prot = PPROT;
    endtask

    task automatic clear_report();
        e_flags = 7'd0; e_valid = 1'b0; e_code = 3'd0; e_addr = '0;
        e_xfer = 0; e_err = 0; e_slv = 0;
    endtask

    // One clock of the protocol rules, applied to the inputs seen at this edge
    task automatic model_step();
        logic [6:0] v;
        bit done, sel, moved;
        int nxt, c;
        if (PRESET) begin
            m_phase = 0; m_waits = 0; m_prev_done = 1'b0;
            clear_report();
            return;
        end
        v = 7'd0; done = 1'b0; nxt = m_phase;
        sel = (PSEL != '0);
        if ($countones(PSEL) > 1) v[0] = 1'b1;
        if (sel && !PWRITE && PSTRB != '0) v[6] = 1'b1;
        if (m_prev_done && PENABLE && m_phase != 2) v[5] = 1'b1;
        case (m_phase)
            0: if (sel) begin
                snap(); m_waits = 0;
                if (PENABLE) begin v[1] = 1'b1; nxt = 2; end else nxt = 1;
            end
            1: if (!sel) begin v[2] = 1'b1; nxt = 0; end
               else if (PENABLE) begin nxt = 2; m_waits = 0; end
               else begin v[2] = 1'b1; snap(); end
            2: if (!sel) begin v[3] = 1'b1; nxt = 0; end
               else begin
                   moved = (PSEL != s_sel) || (PADDR != s_addr) || (PWRITE != s_write) ||
                           (PWDATA != s_wdata) || (PSTRB != s_strb) || (PPROT != s_prot);
                   if (moved) v[3] = 1'b1;
                   if (PREADY) begin
                       done = 1'b1;
                       if (!PENABLE) begin nxt = 1; snap(); end else nxt = 0;
                   end else begin
                       m_waits++;
                       if (m_waits == TO) v[4] = 1'b1;
                   end
               end
            default: nxt = 0;
        endcase
        if (clr) begin
            clear_report();
        end else begin
            if (v != 7'd0) begin
                if (e_flags == 7'd0) begin
                    c = 0;
                    while (!v[c]) c++;
                    e_code = 3'(c);
                    e_addr = PADDR;
                end
                e_flags = e_flags | v;
                if (e_err < CMAX) e_err++;
            end
            e_valid = (v != 7'd0);
            if (done && e_xfer < CMAX) e_xfer++;
            if (done && PSLVERR && e_slv < CMAX) e_slv++;
        end
        m_phase = nxt;
        m_prev_done = done;
    endtask

    task automatic tick();
        @(posedge PCLK);
        model_step();
        #1;
    endtask

    task automatic go_idle();
        PSEL = '0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PSTRB = '0;
    endtask

    task automatic start(input logic [NS-1:0] sel, input logic wr, input logic [AW-1:0] a,
                         input logic [SW-1:0] strb);
        PSEL = sel; PWRITE = wr; PADDR = a; PSTRB = strb; PENABLE = 1'b0;
        PREADY = 1'b0; PSLVERR = 1'b0; PWDATA = 32'hA5A5_0000 | a; PPROT = 3'd2;
    endtask

    task automatic do_clr();
        go_idle(); clr = 1'b1; tick(); clr = 1'b0;
    endtask

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge PCLK);
            if (cmp_en) begin
                chk("err_flags", 64'(err_flags), 64'(e_flags));
                chk("err_valid", 64'(err_valid), 64'(e_valid));
                chk("first_code", 64'(first_code), 64'(e_code));
                chk("first_addr", 64'(first_addr), 64'(e_addr));
                chk("xfer_count", 64'(xfer_count), 64'(e_xfer));
                chk("err_count", 64'(err_count), 64'(e_err));
                chk("slverr_count", 64'(slverr_count), 64'(e_slv));
                chk("mon_state", 64'(mon_state), 64'(m_phase));
            end
        end
    end

    initial begin
        int pulses;
        int r;
        PRESET = 1'b1; clr = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PPROT = 3'd0;
        go_idle();
        tick();
        cmp_en = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("rst_state", 64'(mon_state), 64'd0);
        chk("rst_flags", 64'(err_flags), 64'd0);
        chk("rst_xfer", 64'(xfer_count), 64'd0);

        // clean write with three monitor wait cycles
        start(4'b0010, 1'b1, 32'h1000, 4'hF); tick(); chk("s1_seq0", 64'(mon_state), 64'd1);
        PENABLE = 1'b1; tick(); chk("s1_seq1", 64'(mon_state), 64'd2);
        for (int i = 0; i < 3; i++) begin tick(); chk("s1_seqw", 64'(mon_state), 64'd2); end
        PREADY = 1'b1; tick(); chk("s1_seq5", 64'(mon_state), 64'd0);
        go_idle(); tick();
        chk("s1_flags", 64'(err_flags), 64'd0);
        chk("s1_xfer", 64'(xfer_count), 64'd1);

        // address moves during the second wait cycle
        do_clr();
        pulses = 0;
        start(4'b0010, 1'b1, 32'h1000, 4'hF); tick();
        PENABLE = 1'b1; tick();
        tick(); pulses += int'(err_valid);
        PADDR = 32'h1004; tick(); pulses += int'(err_valid);
        PADDR = 32'h1000; tick(); pulses += int'(err_valid);
        PREADY = 1'b1; tick(); pulses += int'(err_valid);
        go_idle(); tick(); pulses += int'(err_valid);
        chk("s2_flags", 64'(err_flags), 64'h08);
        chk("s2_pulses", 64'(pulses), 64'd1);
        chk("s2_code", 64'(first_code), 64'd3);
        chk("s2_addr", 64'(first_addr), 64'h1004);

        // multi-hot select together with skipped setup
        do_clr();
        start(4'b0011, 1'b1, 32'h2000, 4'h3); PENABLE = 1'b1; tick();
        chk("s3_flags", 64'(err_flags), 64'h03);
        chk("s3_code", 64'(first_code), 64'd0);
        chk("s3_errcnt", 64'(err_count), 64'd1);
        chk("s3_state", 64'(mon_state), 64'd2);
        go_idle(); tick();

        // wait-state timeout
        do_clr();
        pulses = 0;
        start(4'b0100, 1'b1, 32'h3000, 4'hF); tick();
        PENABLE = 1'b1; tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("s4_valid", 64'(err_valid), 64'(k == TO));
            pulses += int'(err_valid);
        end
        PREADY = 1'b1; tick();
        chk("s4_xfer", 64'(xfer_count), 64'd1);
        chk("s4_flags", 64'(err_flags), 64'h10);
        chk("s4_pulses", 64'(pulses), 64'd1);
        go_idle(); tick();

        // read with strobes and slave error, then clear
        do_clr();
        start(4'b0001, 1'b0, 32'h4000, 4'hF); tick();
        PENABLE = 1'b1; tick();
        PREADY = 1'b1; PSLVERR = 1'b1; tick();
        chk("s5_flags", 64'(err_flags), 64'h40);
        chk("s5_slverr", 64'(slverr_count), 64'd1);
        chk("s5_xfer", 64'(xfer_count), 64'd1);
        go_idle(); tick();
        do_clr();
        chk("s5_clr_flags", 64'(err_flags), 64'd0);
        chk("s5_clr_code", 64'(first_code), 64'd0);
        chk("s5_clr_addr", 64'(first_addr), 64'd0);
        chk("s5_clr_counts", 64'({xfer_count, err_count, slverr_count}), 64'd0);

        // reset in the middle of ACCESS
        start(4'b1000, 1'b0, 32'h5000, 4'hF); tick();
        PENABLE = 1'b1; tick();
        tick();
        PRESET = 1'b1; tick();
        chk("s6_state", 64'(mon_state), 64'd0);
        chk("s6_flags", 64'(err_flags), 64'd0);
        chk("s6_valid", 64'(err_valid), 64'd0);
        chk("s6_counts", 64'({xfer_count, err_count, slverr_count}), 64'd0);
        PRESET = 1'b0; go_idle(); tick();
        chk("s6_after", 64'(err_flags), 64'd0);

        // randomized traffic, mostly protocol-like with occasional misbehaviour
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            if (r < 10) PSEL = '0;
            else if (r < 22) PSEL = NS'(1) << $urandom_range(0, NS - 1);
            else if (r < 25) PSEL = NS'($urandom);
            PENABLE = ($urandom_range(0, 99) < 55);
            PREADY  = ($urandom_range(0, 99) < 40);
            PSLVERR = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 10) PWRITE = ~PWRITE;
            if ($urandom_range(0, 99) < 8) PADDR = 32'h1000 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 99) < 5) PWDATA = $urandom;
            if ($urandom_range(0, 99) < 3) PPROT = 3'($urandom);
            if ($urandom_range(0, 99) < 10)
                PSTRB = PWRITE ? SW'($urandom) : (($urandom_range(0, 99) < 30) ? 4'hF : 4'h0);
            clr    = ($urandom_range(0, 99) < 2);
            PRESET = ($urandom_range(0, 299) < 1);
            tick();
        end
        PRESET = 1'b0; clr = 1'b0; go_idle(); tick();
        @(negedge PCLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
